kb_search_ctrl: RTL

KB_SEARCH_CTRL -- requirements
Module: kb_search_ctrl

---
 rtl/kb_pkg.sv | 26 ++
 rtl/kb_search_ctrl_if.sv | 23 ++
 rtl/kb_watchdog.sv | 26 ++
 rtl/kb_search_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared types and constants for the key-block search controller.
// Candidate stepping touches only the low counter field of the key block.
package kb_pkg;

  localparam int KB_W   = 448;
  localparam int KEY_W  = 128;
  localparam int CTR_W  = 64;
  localparam int TRY_W  = 32;
  localparam int WDOG_W = 10;

  localparam logic [WDOG_W-1:0] WDOG_INIT = 10'd1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } kb_state_e;

  // Low counter wraps on its own; the upper key-block bits never see a carry.
  function automatic logic [KB_W-1:0] next_candidate(input logic [KB_W-1:0] kb);
    return {kb[KB_W-1:CTR_W], kb[CTR_W-1:0] + CTR_W'(1)};
  endfunction

endpackage

// File: rtl/kb_search_ctrl_if.sv
// Handshake bundle between the search controller and the aes_kb engine.
interface kb_search_ctrl_if;
  import kb_pkg::*;

  logic             eng_start;
  logic [KEY_W-1:0] eng_in_buf;
  logic [KB_W-1:0]  eng_kb;
  logic             eng_stall;
  logic [KEY_W-1:0] eng_key;
  logic             eng_valid;
  logic             eng_done;

  modport master (
    output eng_start, eng_in_buf, eng_kb, eng_stall,
    input  eng_key, eng_valid, eng_done
  );

  modport slave (
    input  eng_start, eng_in_buf, eng_kb, eng_stall,
    output eng_key, eng_valid, eng_done
  );

endinterface

// File: rtl/kb_watchdog.sv
// Per-attempt watchdog: loadable 10-bit down-counter that parks at zero.
module kb_watchdog
  import kb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= WDOG_INIT;
    end else if (en && (count != '0)) begin
      count <= count - WDOG_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/kb_search_ctrl.sv
// Sequences aes_kb engine attempts over consecutive candidates until a match,
// the attempt limit, a watchdog expiry or an abort ends the search.
module kb_search_ctrl
  import kb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [KEY_W-1:0] in_buf,
  input  logic [KB_W-1:0]  kb_base,
  input  logic [TRY_W-1:0] max_tries,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timeout,
  output logic [KEY_W-1:0] key,
  output logic [KB_W-1:0]  kb_found,
  output logic [TRY_W-1:0] tries,
  kb_search_ctrl_if.master eng
);

  kb_state_e        state;
  logic [TRY_W-1:0] limit;
  logic [TRY_W-1:0] tries_inc;
  logic [KB_W-1:0]  cand;
  logic [KEY_W-1:0] hash;
  logic [KEY_W-1:0] key_q;
  logic             match_q;
  logic             start_q;
  logic             active;
  logic             frozen;
  logic             wd_load;
  logic             wd_en;
  logic             wd_zero;

  assign active    = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_CHECK);
  assign frozen    = active && pause;
  assign tries_inc = tries + TRY_W'(1);
  assign wd_load   = (state == ST_LAUNCH) && !pause && !abort;
  assign wd_en     = (state == ST_WAIT) && !pause && !abort;

  // A due start is held while paused and only escapes on a live cycle.
  assign eng.eng_start  = start_q && !pause && !abort;
  assign eng.eng_stall  = pause;
  assign eng.eng_kb     = cand;
  assign eng.eng_in_buf = hash;

  kb_watchdog u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .load (wd_load),
    .en   (wd_en),
    .zero (wd_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      timeout  <= 1'b0;
      key      <= '0;
      kb_found <= '0;
      tries    <= '0;
      limit    <= '0;
      cand     <= '0;
      hash     <= '0;
      key_q    <= '0;
      match_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (active && abort) begin
        state   <= ST_FINISH;
        done    <= 1'b1;
        found   <= 1'b0;
        timeout <= 1'b0;
        start_q <= 1'b0;
      end else if (!frozen) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_LAUNCH;
              busy    <= 1'b1;
              start_q <= 1'b1;
              hash    <= in_buf;
              cand    <= kb_base;
              limit   <= max_tries;
              tries   <= '0;
              found   <= 1'b0;
              timeout <= 1'b0;
            end
          end
          ST_LAUNCH: begin
            start_q <= 1'b0;
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            if (eng.eng_done) begin
              match_q <= eng.eng_valid;
              key_q   <= eng.eng_key;
              state   <= ST_CHECK;
            end else if (wd_zero) begin
              timeout <= 1'b1;
              done    <= 1'b1;
              state   <= ST_FINISH;
            end
          end
          ST_CHECK: begin
            tries <= tries_inc;
            // A limit of zero is reached only when the 32-bit count wraps.
            if (match_q) begin
              found    <= 1'b1;
              key      <= key_q;
              kb_found <= cand;
              done     <= 1'b1;
              state    <= ST_FINISH;
            end else if (tries_inc == limit) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              cand    <= next_candidate(cand);
              start_q <= 1'b1;
              state   <= ST_LAUNCH;
            end
          end
          ST_FINISH: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
